// File: rtl/matmul_ctrl.sv
// Sequencer for a MAC array: per output column it clears the accumulators, streams K
// operand beats from the input/weight buffers, waits for the result and hands it out.
module matmul_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OUTPUT_WIDTH = 8,
    parameter int unsigned MAC_NUM      = 8,
    parameter int unsigned K_WIDTH      = 5,
    parameter int unsigned N_WIDTH      = 4,
    parameter int unsigned WADDR_WIDTH  = 8,
    parameter int unsigned TIMEOUT      = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [K_WIDTH-1:0]              cfg_k_i,
    input  logic [N_WIDTH-1:0]              cfg_n_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic                            buf_rd_o,
    output logic [K_WIDTH-1:0]              din_addr_o,
    output logic [WADDR_WIDTH-1:0]          win_addr_o,
    output logic                            mac_clear_o,
    output logic                            mac_en_o,
    output logic                            mac_valid_o,
    output logic                            mac_last_o,
    input  logic                            mac_done_i,
    input  logic [OUTPUT_WIDTH*MAC_NUM-1:0] matmul_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [OUTPUT_WIDTH*MAC_NUM-1:0] res_data_o,
    output logic [N_WIDTH-1:0]              res_col_o
);

    // Operands flow buffer->MAC directly, so DATA_WIDTH only documents the datapath.
    localparam int unsigned ResW = OUTPUT_WIDTH * MAC_NUM + 0 * DATA_WIDTH;
    localparam int unsigned TW   = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StWait,
        StOut
    } state_e;

    state_e                 state_q, state_d;
    logic [K_WIDTH-1:0]     klat_q, klat_d;
    logic [N_WIDTH-1:0]     nlat_q, nlat_d;
    logic [K_WIDTH-1:0]     k_q, k_d;
    logic [N_WIDTH-1:0]     n_q, n_d;
    logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [ResW-1:0]        rdata_q, rdata_d;
    logic [N_WIDTH-1:0]     rcol_q, rcol_d;

    logic cfg_legal;
    logic k_last;
    logic n_last;

    assign cfg_legal = (cfg_k_i != '0) && (32'(cfg_k_i) <= 32'd16) && (cfg_n_i != '0);
    assign k_last    = (k_q == klat_q - K_WIDTH'(1));
    assign n_last    = (n_q == nlat_q - N_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        klat_d  = klat_q;
        nlat_d  = nlat_q;
        k_d     = k_q;
        n_d     = n_q;
        waddr_d = waddr_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        rcol_d  = rcol_q;
        valid_d = (state_q == StFeed);
        last_d  = (state_q == StFeed) && k_last;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    klat_d  = cfg_k_i;
                    nlat_d  = cfg_n_i;
                    n_d     = '0;
                    k_d     = '0;
                    // Weight addresses are contiguous across columns, so one running count suffices.
                    waddr_d = '0;
                    if (cfg_legal) begin
                        err_d   = 1'b0;
                        state_d = StClear;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            StClear: begin
                k_d     = '0;
                state_d = StFeed;
            end
            StFeed: begin
                k_d     = k_q + K_WIDTH'(1);
                waddr_d = waddr_q + WADDR_WIDTH'(1);
                if (k_last) begin
                    tcnt_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mac_done_i) begin
                    rdata_d = matmul_i;
                    rcol_d  = n_q;
                    state_d = StOut;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StOut: begin
                if (res_ready_i) begin
                    if (n_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        n_d     = n_q + N_WIDTH'(1);
                        state_d = StClear;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything that happened above and leaves err untouched.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
            err_d   = err_q;
            valid_d = 1'b0;
            last_d  = 1'b0;
            rdata_d = rdata_q;
            rcol_d  = rcol_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            klat_q  <= '0;
            nlat_q  <= '0;
            k_q     <= '0;
            n_q     <= '0;
            waddr_q <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            rdata_q <= '0;
            rcol_q  <= '0;
        end else begin
            state_q <= state_d;
            klat_q  <= klat_d;
            nlat_q  <= nlat_d;
            k_q     <= k_d;
            n_q     <= n_d;
            waddr_q <= waddr_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            rcol_q  <= rcol_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign buf_rd_o    = (state_q == StFeed);
    assign din_addr_o  = k_q;
    assign win_addr_o  = waddr_q;
    assign mac_clear_o = (state_q == StClear);
    assign mac_en_o    = (state_q == StClear) || (state_q == StFeed) || (state_q == StWait);
    assign mac_valid_o = valid_q;
    assign mac_last_o  = last_q;
    assign res_valid_o = (state_q == StOut);
    assign res_data_o  = rdata_q;
    assign res_col_o   = rcol_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Randomized bench for matmul_ctrl: each job's cycle schedule is derived from K, N and the
// chosen mac_done/ready delays, and every output is compared against it.
module tb_matmul_ctrl;

    localparam int TIMEOUT = 32;
    localparam int RW      = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic [4:0]    cfg_k_i;
    logic [3:0]    cfg_n_i;
    logic          busy_o, done_o, err_o, buf_rd_o;
    logic [4:0]    din_addr_o;
    logic [7:0]    win_addr_o;
    logic          mac_clear_o, mac_en_o, mac_valid_o, mac_last_o;
    logic          mac_done_i;
    logic [RW-1:0] matmul_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [RW-1:0] res_data_o;
    logic [3:0]    res_col_o;

    int n_vec = 0;
    int n_err = 0;

    matmul_ctrl #(
        .DATA_WIDTH  (8),
        .OUTPUT_WIDTH(8),
        .MAC_NUM     (8),
        .K_WIDTH     (5),
        .N_WIDTH     (4),
        .WADDR_WIDTH (8),
        .TIMEOUT     (TIMEOUT)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .cfg_k_i    (cfg_k_i),
        .cfg_n_i    (cfg_n_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .buf_rd_o   (buf_rd_o),
        .din_addr_o (din_addr_o),
        .win_addr_o (win_addr_o),
        .mac_clear_o(mac_clear_o),
        .mac_en_o   (mac_en_o),
        .mac_valid_o(mac_valid_o),
        .mac_last_o (mac_last_o),
        .mac_done_i (mac_done_i),
        .matmul_i   (matmul_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_data_o (res_data_o),
        .res_col_o  (res_col_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".busy"}, busy_o, 0);
        check_eq({tag, ".done"}, done_o, 0);
        check_eq({tag, ".err"}, err_o, 0);
        check_eq({tag, ".buf_rd"}, buf_rd_o, 0);
        check_eq({tag, ".din"}, din_addr_o, 0);
        check_eq({tag, ".win"}, win_addr_o, 0);
        check_eq({tag, ".clear"}, mac_clear_o, 0);
        check_eq({tag, ".en"}, mac_en_o, 0);
        check_eq({tag, ".valid"}, mac_valid_o, 0);
        check_eq({tag, ".last"}, mac_last_o, 0);
        check_eq({tag, ".res_valid"}, res_valid_o, 0);
        check_eq({tag, ".res_data"}, res_data_o, 0);
        check_eq({tag, ".res_col"}, res_col_o, 0);
    endtask

    // Inputs that a running job must ignore.
    task automatic noise(input bit with_done);
        cfg_k_i  = 5'($urandom);
        cfg_n_i  = 4'($urandom);
        start_i  = 1'($urandom);
        matmul_i = {$urandom, $urandom};
        if (with_done) mac_done_i = 1'($urandom);
    endtask

    task automatic start_job(input int k, input int n);
        cfg_k_i = 5'(k);
        cfg_n_i = 4'(n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // d/r < 0 pick random mac_done delay / ready hold per column.
    task automatic run_job(input int k, input int n, input int d_fix, input int r_fix);
        logic [RW-1:0] data;
        int d, r;
        start_job(k, n);
        for (int col = 0; col < n; col++) begin
            check_eq("clr.clear", mac_clear_o, 1);
            check_eq("clr.en", mac_en_o, 1);
            check_eq("clr.busy", busy_o, 1);
            check_eq("clr.rd", buf_rd_o, 0);
            noise(1'b1);
            tick();
            for (int kk = 0; kk < k; kk++) begin
                check_eq("feed.rd", buf_rd_o, 1);
                check_eq("feed.din", din_addr_o, kk);
                check_eq("feed.win", win_addr_o, (col * k + kk) % 256);
                check_eq("feed.valid", mac_valid_o, (kk > 0) ? 1 : 0);
                check_eq("feed.last", mac_last_o, 0);
                check_eq("feed.en", mac_en_o, 1);
                check_eq("feed.clear", mac_clear_o, 0);
                noise(1'b1);
                tick();
            end
            d    = (d_fix < 0) ? int'($urandom_range(0, 5)) : d_fix;
            data = {$urandom, $urandom};
            for (int j = 0; j <= d; j++) begin
                check_eq("wait.rd", buf_rd_o, 0);
                check_eq("wait.en", mac_en_o, 1);
                check_eq("wait.valid", mac_valid_o, (j == 0) ? 1 : 0);
                check_eq("wait.last", mac_last_o, (j == 0) ? 1 : 0);
                check_eq("wait.res_valid", res_valid_o, 0);
                noise(1'b0);
                mac_done_i = (j == d);
                if (j == d) matmul_i = data;
                tick();
            end
            mac_done_i = 1'b0;
            r = (r_fix < 0) ? int'($urandom_range(0, 3)) : r_fix;
            for (int j = 0; j <= r; j++) begin
                check_eq("out.valid", res_valid_o, 1);
                check_eq("out.data", res_data_o, data);
                check_eq("out.col", res_col_o, col);
                check_eq("out.en", mac_en_o, 0);
                check_eq("out.clear", mac_clear_o, 0);
                check_eq("out.done", done_o, 0);
                noise(1'b1);
                res_ready_i = (j == r);
                tick();
            end
            res_ready_i = 1'b0;
            start_i     = 1'b0;
            mac_done_i  = 1'b0;
            check_eq("post.res_valid", res_valid_o, 0);
        end
        check_eq("end.done", done_o, 1);
        check_eq("end.busy", busy_o, 0);
        check_eq("end.err", err_o, 0);
        tick();
        check_eq("end.done_pulse", done_o, 0);
    endtask

    task automatic illegal(input int k, input int n);
        start_job(k, n);
        check_eq("ill.done", done_o, 1);
        check_eq("ill.err", err_o, 1);
        check_eq("ill.busy", busy_o, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check_eq("ill.done_pulse", done_o, 0);
            check_eq("ill.busy_idle", busy_o, 0);
            check_eq("ill.rd", buf_rd_o, 0);
            check_eq("ill.err_sticky", err_o, 1);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        cfg_k_i     = '0;
        cfg_n_i     = '0;
        mac_done_i  = 1'b0;
        matmul_i    = '0;
        res_ready_i = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        run_job(4, 2, 2, 0);    // nominal
        run_job(4, 3, -1, 5);   // back-pressure
        illegal(0, 3);
        illegal(int'($urandom_range(17, 31)), 2);
        illegal(3, 0);

        // Timeout: WAIT entered at cycle K+2 = 4, done expected at 4+TIMEOUT.
        start_job(2, 1);
        for (int c = 1; c <= 4 + TIMEOUT + 1; c++) begin
            if (c < 4 + TIMEOUT) begin
                check_eq("to.done", done_o, 0);
                check_eq("to.busy", busy_o, 1);
            end else if (c == 4 + TIMEOUT) begin
                check_eq("to.done_fire", done_o, 1);
                check_eq("to.err", err_o, 1);
                check_eq("to.busy_end", busy_o, 0);
            end else begin
                check_eq("to.done_after", done_o, 0);
                check_eq("to.busy_after", busy_o, 0);
            end
            tick();
        end

        // Abort during FEED at k=2 (cycle 4).
        start_job(4, 2);
        tick();
        tick();
        tick();
        check_eq("ab.din", din_addr_o, 2);
        check_eq("ab.rd", buf_rd_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_eq("ab.busy", busy_o, 0);
        check_eq("ab.rd_low", buf_rd_o, 0);
        check_eq("ab.valid", mac_valid_o, 0);
        check_eq("ab.last", mac_last_o, 0);
        check_eq("ab.en", mac_en_o, 0);
        check_eq("ab.done", done_o, 0);
        check_eq("ab.err", err_o, 0);
        tick();
        check_eq("ab.done_later", done_o, 0);

        // Abort beats a simultaneous mac_done in WAIT (K=1: WAIT at cycle 3).
        start_job(1, 1);
        tick();
        tick();
        mac_done_i = 1'b1;
        abort_i    = 1'b1;
        tick();
        mac_done_i = 1'b0;
        abort_i    = 1'b0;
        check_eq("abw.res_valid", res_valid_o, 0);
        check_eq("abw.busy", busy_o, 0);
        check_eq("abw.done", done_o, 0);

        // Reset during WAIT (K=2: WAIT at cycle 4), then stray mac_done in IDLE.
        start_job(2, 1);
        tick();
        tick();
        tick();
        check_eq("rw.busy", busy_o, 1);
        check_eq("rw.en", mac_en_o, 1);
        rst_i      = 1'b1;
        start_i    = 1'b1;
        mac_done_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        check_all_zero("rst_mid");
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq("stray.busy", busy_o, 0);
            check_eq("stray.res_valid", res_valid_o, 0);
            check_eq("stray.done", done_o, 0);
        end
        mac_done_i = 1'b0;
        tick();

        run_job(16, 15, -1, -1); // boundary, last weight address 239
        for (int i = 0; i < 12; i++) begin
            run_job(int'($urandom_range(1, 16)), int'($urandom_range(1, 5)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
